// File: rtl/count_mod_n_pkg.sv
// Shared constants and types for the modulo-N counter family.
package count_mod_n_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_STEP,
    SEL_LOAD
  } cnt_sel_e;

endpackage

// File: rtl/count_mod_n_regn.sv
// Parametrised D register with synchronous active-high reset and enable.
module regn #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_res,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/count_mod_n.sv
// Modulo-(MAX+1) up/down counter with load, enable, terminal count and wrap pulse.
module count_mod_n
  import count_mod_n_pkg::*;
#(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MAX      = 255,
  parameter int unsigned     SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             res,
  input  logic             EN,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] CNT_In,
  output logic [WIDTH-1:0] CNT,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("count_mod_n: WIDTH must be in 2..32");
  end
  if (MAX < 1 || MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("count_mod_n: MAX must be in 1..2**WIDTH-1");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
    $error("count_mod_n: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic             SAT   = (SATURATE == MODE_SAT);

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_end;
  logic             w_wrap_step;
  logic             w_reg_en;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_step_val;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_next;
  cnt_sel_e         w_sel;
  logic             r_wrap;

  assign w_at_max  = (CNT == MAX_V);
  assign w_at_zero = (CNT == '0);
  assign w_end     = (up == DIR_UP) ? w_at_max : w_at_zero;

  // Down-count adds all-ones with carry-in 0; the carry-out is deliberately dropped,
  // end-of-range is taken from the MAX/zero compares instead.
  assign w_addend = (up == DIR_UP) ? '0 : '1;
  assign w_sum    = CNT + w_addend + {{(WIDTH-1){1'b0}}, up};

  always_comb begin
    w_step_val  = w_sum;
    w_wrap_step = 1'b0;
    if (w_end) begin
      if (SAT) begin
        w_step_val = CNT;
      end else begin
        w_step_val  = (up == DIR_DOWN) ? MAX_V : '0;
        w_wrap_step = 1'b1;
      end
    end
  end

  assign w_load_val = (CNT_In > MAX_V) ? MAX_V : CNT_In;

  always_comb begin
    w_sel = SEL_HOLD;
    if (load) begin
      w_sel = SEL_LOAD;
    end else if (EN) begin
      w_sel = SEL_STEP;
    end
  end

  always_comb begin
    w_next = CNT;
    case (w_sel)
      SEL_LOAD: w_next = w_load_val;
      SEL_STEP: w_next = w_step_val;
      default:  w_next = CNT;
    endcase
  end

  assign w_reg_en = (w_sel != SEL_HOLD);

  regn #(
    .WIDTH(WIDTH)
  ) u_cnt_reg (
    .i_clk (clk),
    .i_res (res),
    .i_en  (w_reg_en),
    .i_d   (w_next),
    .o_q   (CNT)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= (w_sel == SEL_STEP) && w_wrap_step;
    end
  end

  assign wrap = r_wrap;
  assign tc   = EN & w_end;

endmodule
